// File: rtl/bram_pkg.sv
// Shared constants for the dual-bank BRAM responder: default geometry,
// write-cycle read modes and sticky error-bit positions.
package bram_pkg;

    localparam int BRAM_DATA_W = 8;
    localparam int BRAM_ADDR_W = 5;
    localparam int BRAM_DEPTH  = 32;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int ERR_UNWRITTEN = 0;
    localparam int ERR_OOR       = 1;

endpackage

// File: rtl/bram_dual_bank_responder_bank.sv
// One single-port BRAM bank: storage, written-address bitmap, distinct-write
// counter, sticky error flags and a 1- or 2-stage read-valid pipeline.
module bram_bank
    import bram_pkg::*;
#(
    parameter int DATA_W    = BRAM_DATA_W,
    parameter int ADDR_W    = BRAM_ADDR_W,
    parameter int DEPTH     = BRAM_DEPTH,
    parameter int RD_LAT    = 1,
    parameter int READ_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic [ADDR_W:0]   cnt,
    output logic              full,
    output logic [1:0]        err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  written_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        err_r;
    logic [DATA_W-1:0] s1_data_r;
    logic              s1_valid_r;

    logic              in_range_s;
    logic              hit_s;
    logic [DATA_W-1:0] stored_s;
    logic [DATA_W-1:0] resp_s;
    logic              do_write_s;
    logic              set_unwr_s;
    logic              set_oor_s;
    logic              cnt_inc_s;

    // Decode the current access: range, bitmap hit, response word and side effects
    always_comb begin
        in_range_s = ({1'b0, addr} < DEPTH_C);
        hit_s      = 1'b0;
        stored_s   = {DATA_W{1'b0}};
        resp_s     = {DATA_W{1'b0}};
        if (in_range_s) begin
            hit_s    = written_r[addr];
            stored_s = mem_r[addr];
        end else begin
            hit_s    = 1'b0;
            stored_s = {DATA_W{1'b0}};
        end

        // Unwritten words read as zero so stale array contents never leak out
        if (!in_range_s) begin
            resp_s = {DATA_W{1'b0}};
        end else if (wea && (READ_MODE == WRITE_FIRST)) begin
            resp_s = din;
        end else if (hit_s) begin
            resp_s = stored_s;
        end else begin
            resp_s = {DATA_W{1'b0}};
        end

        do_write_s = ena && wea && in_range_s;
        set_unwr_s = ena && !wea && in_range_s && !hit_s;
        set_oor_s  = ena && !in_range_s;
        cnt_inc_s  = do_write_s && !hit_s && (cnt_r != DEPTH_C);
    end

    // Storage array; deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[addr] <= din;
        end
    end

    // Bitmap, counter, sticky errors and first read stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written_r  <= {DEPTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            err_r      <= 2'b00;
            s1_data_r  <= {DATA_W{1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= ena;
            if (ena) begin
                s1_data_r <= resp_s;
            end
            if (do_write_s) begin
                written_r[addr] <= 1'b1;
            end
            if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (set_unwr_s) begin
                err_r[ERR_UNWRITTEN] <= 1'b1;
            end
            if (set_oor_s) begin
                err_r[ERR_OOR] <= 1'b1;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_r;
            logic              s2_valid_r;

            // Output register stage; data holds between valid pulses
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s2_data_r  <= {DATA_W{1'b0}};
                    s2_valid_r <= 1'b0;
                end else begin
                    s2_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        s2_data_r <= s1_data_r;
                    end
                end
            end

            assign dout  = s2_data_r;
            assign valid = s2_valid_r;
        end else begin : g_lat1
            assign dout  = s1_data_r;
            assign valid = s1_valid_r;
        end
    endgenerate

    assign cnt  = cnt_r;
    assign full = (cnt_r == DEPTH_C);
    assign err  = err_r;

endmodule

// File: rtl/bram_dual_bank_responder.sv
// Two independent single-port BRAM banks (A and B) answering the controller's
// per-bank strobes; this level only wires the two bank instances.
module bram_dual_bank_responder
    import bram_pkg::*;
#(
    parameter int DATA_W    = BRAM_DATA_W,
    parameter int ADDR_W    = BRAM_ADDR_W,
    parameter int DEPTH     = BRAM_DEPTH,
    parameter int RD_LAT    = 1,
    parameter int READ_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_A,
    input  logic              wea_A,
    input  logic [ADDR_W-1:0] addra_A,
    input  logic [DATA_W-1:0] dina_A,
    output logic [DATA_W-1:0] douta_A,
    output logic              valida_A,
    output logic [ADDR_W:0]   cnt_A,
    output logic              full_A,
    output logic [1:0]        err_A,
    input  logic              ena_B,
    input  logic              wea_B,
    input  logic [ADDR_W-1:0] addra_B,
    input  logic [DATA_W-1:0] dina_B,
    output logic [DATA_W-1:0] douta_B,
    output logic              valida_B,
    output logic [ADDR_W:0]   cnt_B,
    output logic              full_B,
    output logic [1:0]        err_B
);

    bram_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .RD_LAT(RD_LAT), .READ_MODE(READ_MODE)
    ) u_bank_a (
        .clk(clk), .rst(rst),
        .ena(ena_A), .wea(wea_A), .addr(addra_A), .din(dina_A),
        .dout(douta_A), .valid(valida_A), .cnt(cnt_A), .full(full_A), .err(err_A)
    );

    bram_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .RD_LAT(RD_LAT), .READ_MODE(READ_MODE)
    ) u_bank_b (
        .clk(clk), .rst(rst),
        .ena(ena_B), .wea(wea_B), .addr(addra_B), .din(dina_B),
        .dout(douta_B), .valid(valida_B), .cnt(cnt_B), .full(full_B), .err(err_B)
    );

endmodule

// File: tb/tb_bram_dual_bank_responder.sv
// Scoreboard bench: two responders (RD_LAT=1 read-first, RD_LAT=2 write-first)
// share one stimulus stream and are checked against a behavioural bank model.
module tb_bram_dual_bank_responder;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ena_A, wea_A, ena_B, wea_B;
    logic [4:0] addra_A, addra_B;
    logic [7:0] dina_A, dina_B;

    logic [7:0] douta_A1, douta_B1, douta_A2, douta_B2;
    logic       valida_A1, valida_B1, valida_A2, valida_B2;
    logic [5:0] cnt_A1, cnt_B1, cnt_A2, cnt_B2;
    logic       full_A1, full_B1, full_A2, full_B2;
    logic [1:0] err_A1, err_B1, err_A2, err_B2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t qa1[$], qb1[$], qa2[$], qb2[$];

    logic [7:0]  m_mem [2][32];
    logic [31:0] m_wr  [2];
    int          m_cnt [2];
    logic [1:0]  m_err [2];

    bram_dual_bank_responder #(.RD_LAT(1), .READ_MODE(0)) u_dut_rf (
        .clk(clk), .rst(rst),
        .ena_A(ena_A), .wea_A(wea_A), .addra_A(addra_A), .dina_A(dina_A),
        .douta_A(douta_A1), .valida_A(valida_A1), .cnt_A(cnt_A1), .full_A(full_A1), .err_A(err_A1),
        .ena_B(ena_B), .wea_B(wea_B), .addra_B(addra_B), .dina_B(dina_B),
        .douta_B(douta_B1), .valida_B(valida_B1), .cnt_B(cnt_B1), .full_B(full_B1), .err_B(err_B1)
    );

    bram_dual_bank_responder #(.RD_LAT(2), .READ_MODE(1)) u_dut_wf (
        .clk(clk), .rst(rst),
        .ena_A(ena_A), .wea_A(wea_A), .addra_A(addra_A), .dina_A(dina_A),
        .douta_A(douta_A2), .valida_A(valida_A2), .cnt_A(cnt_A2), .full_A(full_A2), .err_A(err_A2),
        .ena_B(ena_B), .wea_B(wea_B), .addra_B(addra_B), .dina_B(dina_B),
        .douta_B(douta_B2), .valida_B(valida_B2), .cnt_B(cnt_B2), .full_B(full_B2), .err_B(err_B2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every cycle, valid must match whether an expectation is due now
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check_eq("a1_valid", 32'(valida_A1), 32'(qa1.size() > 0 && qa1[0].cyc == cyc));
            if (valida_A1 && qa1.size() > 0) begin
                e = qa1.pop_front();
                check_eq("a1_data", 32'(douta_A1), 32'(e.data));
            end
            check_eq("b1_valid", 32'(valida_B1), 32'(qb1.size() > 0 && qb1[0].cyc == cyc));
            if (valida_B1 && qb1.size() > 0) begin
                e = qb1.pop_front();
                check_eq("b1_data", 32'(douta_B1), 32'(e.data));
            end
            check_eq("a2_valid", 32'(valida_A2), 32'(qa2.size() > 0 && qa2[0].cyc == cyc));
            if (valida_A2 && qa2.size() > 0) begin
                e = qa2.pop_front();
                check_eq("a2_data", 32'(douta_A2), 32'(e.data));
            end
            check_eq("b2_valid", 32'(valida_B2), 32'(qb2.size() > 0 && qb2[0].cyc == cyc));
            if (valida_B2 && qb2.size() > 0) begin
                e = qb2.pop_front();
                check_eq("b2_data", 32'(douta_B2), 32'(e.data));
            end
        end
    end

    task automatic model(input int b, input logic we, input logic [4:0] a, input logic [7:0] d,
                         output logic [7:0] rf, output logic [7:0] wf);
        logic [7:0] old;
        old = m_wr[b][a] ? m_mem[b][a] : 8'h00;
        rf  = old;
        wf  = we ? d : old;
        if (we) begin
            if (!m_wr[b][a] && m_cnt[b] < 32) m_cnt[b]++;
            m_wr[b][a]  = 1'b1;
            m_mem[b][a] = d;
        end else if (!m_wr[b][a]) begin
            m_err[b][0] = 1'b1;
        end
    endtask

    task automatic drive(input logic ea, input logic wa, input logic [4:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [4:0] ab, input logic [7:0] db);
        logic [7:0] rf, wf;
        ena_A = ea; wea_A = wa; addra_A = aa; dina_A = da;
        ena_B = eb; wea_B = wb; addra_B = ab; dina_B = db;
        if (ea) begin
            model(0, wa, aa, da, rf, wf);
            qa1.push_back('{data: rf, cyc: cyc + 1});
            qa2.push_back('{data: wf, cyc: cyc + 2});
        end
        if (eb) begin
            model(1, wb, ab, db, rf, wf);
            qb1.push_back('{data: rf, cyc: cyc + 1});
            qb2.push_back('{data: wf, cyc: cyc + 2});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        ena_A = 1'b0; wea_A = 1'b0; ena_B = 1'b0; wea_B = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model_state();
        qa1.delete(); qb1.delete(); qa2.delete(); qb2.delete();
        for (int b = 0; b < 2; b++) begin
            m_wr[b]  = 32'h0;
            m_cnt[b] = 0;
            m_err[b] = 2'b00;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_cntA1"}, 32'(cnt_A1), 32'(m_cnt[0]));
        check_eq({tag, "_cntA2"}, 32'(cnt_A2), 32'(m_cnt[0]));
        check_eq({tag, "_cntB1"}, 32'(cnt_B1), 32'(m_cnt[1]));
        check_eq({tag, "_cntB2"}, 32'(cnt_B2), 32'(m_cnt[1]));
        check_eq({tag, "_fullA1"}, 32'(full_A1), 32'(m_cnt[0] == 32));
        check_eq({tag, "_fullB2"}, 32'(full_B2), 32'(m_cnt[1] == 32));
        check_eq({tag, "_errA1"}, 32'(err_A1), 32'(m_err[0]));
        check_eq({tag, "_errA2"}, 32'(err_A2), 32'(m_err[0]));
        check_eq({tag, "_errB1"}, 32'(err_B1), 32'(m_err[1]));
        check_eq({tag, "_errB2"}, 32'(err_B2), 32'(m_err[1]));
    endtask

    initial begin
        rst = 1'b0;
        ena_A = 1'b0; wea_A = 1'b0; addra_A = 5'd0; dina_A = 8'h00;
        ena_B = 1'b0; wea_B = 1'b0; addra_B = 5'd0; dina_B = 8'h00;
        clear_model_state();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_doutA1", 32'(douta_A1), 32'h0);
        check_eq("rst_doutB2", 32'(douta_B2), 32'h0);
        check_eq("rst_validA2", 32'(valida_A2), 32'h0);
        check_state("rst");

        // 1: read of unwritten address
        drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(3);
        check_eq("t1_errA1", 32'(err_A1), 32'h1);
        check_state("t1");

        // 2: write then back-to-back read
        drive(1'b1, 1'b1, 5'd7, 8'hA5, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(3);
        check_eq("t2_cntA1", 32'(cnt_A1), 32'd1);
        check_eq("t2_holdA1", 32'(douta_A1), 32'hA5);
        check_state("t2");

        // 3: rewrite of one B address, read-first vs write-first outputs
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h11);
        drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h22);
        idle(3);
        check_eq("t3_cntB1", 32'(cnt_B1), 32'd1);
        check_eq("t3_errB2", 32'(err_B2), 32'h0);
        check_state("t3");

        // 5: same-cycle A write / B read of the same address
        drive(1'b1, 1'b1, 5'd9, 8'h3C, 1'b1, 1'b0, 5'd9, 8'h00);
        drive(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(3);
        check_eq("t5_errB1", 32'(err_B1), 32'h1);
        check_state("t5");

        // 4: fill all of A, then a rewrite that must not count
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 8'(i), 1'b0, 1'b0, 5'd0, 8'h00);
        end
        idle(3);
        check_eq("t4_cntA1", 32'(cnt_A1), 32'd32);
        check_eq("t4_fullA2", 32'(full_A2), 32'h1);
        drive(1'b1, 1'b1, 5'd5, 8'h55, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(3);
        check_eq("t4_satA2", 32'(cnt_A2), 32'd32);
        check_state("t4");

        // Random mixed traffic on both banks
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  8'($urandom_range(0, 255)));
        end
        idle(4);
        check_state("rnd");

        // 6: reset with a read in flight
        drive(1'b1, 1'b0, 5'd10, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
        ena_A = 1'b0;
        #1;
        rst = 1'b0;
        clear_model_state();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_eq("t6_validA2", 32'(valida_A2), 32'h0);
        check_eq("t6_doutA2", 32'(douta_A2), 32'h0);
        check_eq("t6_doutA1", 32'(douta_A1), 32'h0);
        check_eq("t6_cntA1", 32'(cnt_A1), 32'd0);
        idle(4);
        check_state("t6_post");
        drive(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(4);
        check_eq("t6_errA2", 32'(err_A2), 32'h1);
        check_state("t6_rd");

        check_eq("queues_drained", 32'(qa1.size() + qb1.size() + qa2.size() + qb2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_dual_bank_responder.md
Name: bram_dual_bank_responder

Overview:
- Memory-side responder for the two-bank BRAM controller. It consumes the controller's per-bank enable, write-enable and address strobes (ena_A/wea_A/addra_A, ena_B/wea_B/addra_B) and behaves as two independent single-port block RAMs (bank A, bank B).
- Adds per-bank read-valid pipelining, a written-address bitmap with occupancy count, and sticky error flags, so integration benches can check the controller's access ordering cycle by cycle.

Parameters:
- DATA_W, 8, word width of each bank.
- ADDR_W, 5, address width, matching the controller's 5-bit addresses.
- DEPTH, 32, words per bank. Must be ≤ 2**ADDR_W.
- RD_LAT, 1, read latency in cycles. Legal values are 1 (no output register) or 2 (output register).
- READ_MODE, 0, data returned on a write cycle. 0 = read-first (old word), 1 = write-first (new word).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena_A  in  1  bank A access enable.
- wea_A  in  1  bank A write enable; qualified by ena_A.
- addra_A  in  ADDR_W  bank A address.
- dina_A  in  DATA_W  bank A write data.
- douta_A  out  DATA_W  bank A read data.
- valida_A  out  1  douta_A holds the result of an access.
- cnt_A  out  ADDR_W+1  number of distinct bank A addresses written since reset.
- full_A  out  1  cnt_A == DEPTH.
- err_A  out  2  sticky flags: [0] read of an unwritten address; [1] out-of-range address.
- ena_B, wea_B, addra_B, dina_B, douta_B, valida_B, cnt_B, full_B, err_B: identical semantics for bank B.

Behaviour:
- Reset (rst=0, async assert, sync release):
  - douta=0, valid=0, cnt=0, full=0, err=0.
  - Written bitmap cleared; read pipeline flushed.
  - Memory array is not cleared.
  - Reset mid-access discards any in-flight read; no valid pulse follows the release.
- Banks are fully independent. Simultaneous A and B accesses at the same address never interact.
- Access cycle:
  - Defined as ena=1 at a rising edge.
  - Write: ena=1 and wea=1. Read: ena=1 and wea=0.
  - ena=0: no state change; wea and addr are ignored.
- Write:
  - mem[addr] <= din.
  - The bitmap bit for addr is set.
  - cnt increments only if that bit was previously clear. Rewrites do not count; cnt saturates at DEPTH.
- Read data:
  - If the bitmap bit is set: mem[addr].
  - If the bitmap bit is clear: 0, and err[0] is set.
- Write-cycle output:
  - READ_MODE=0: pre-write content, with the unwritten rule applied. A write to an unwritten address returns 0 but does not set err[0].
  - READ_MODE=1: din.
- Latency:
  - valid and dout update RD_LAT cycles after the access edge.
  - valid is high for exactly one cycle per access.
  - Back-to-back accesses give back-to-back valid pulses, with no bubbles.
- dout holds its last value while valid=0 (BRAM-like hold). It is not zeroed.
- Out-of-range (addr ≥ DEPTH):
  - Write is ignored; a read returns 0.
  - valid is still pulsed; err[1] is set.
  - Cannot occur when DEPTH = 2**ADDR_W.
- full_A/full_B are combinational from cnt.
- err bits clear only on reset.

Decomposition:
- Package bram_pkg:
  - Default DATA_W, ADDR_W, DEPTH constants.
  - READ_FIRST=0 and WRITE_FIRST=1 constants.
  - Error-bit index constants ERR_UNWRITTEN=0 and ERR_OOR=1.
- Sub-module bram_bank holds one port's memory array, bitmap, counter, error logic and RD_LAT pipeline.
- The top instantiates bram_bank twice (A and B) and only wires ports.

Test Plan:
1. Reset, then read addr 3 on A with RD_LAT=1 → valida_A pulses on the next edge, douta_A=0x00, err_A=2'b01.
2. Write 0xA5 to A addr 7, then read addr 7 on the next cycle → valida_A pulses for each access and douta_A=0xA5 on the read; cnt_A=1. Repeat with RD_LAT=2 → each valid pulse is delayed one extra cycle.
3. Write 0x11 then 0x22 to B addr 0 → READ_MODE=0 gives write outputs 0x00 then 0x11; READ_MODE=1 gives 0x11 then 0x22. cnt_B=1 in both modes and err_B stays 0.
4. Write all 32 addresses of A with data=addr → cnt_A reaches 32 and full_A=1. A 33rd write to addr 5 leaves cnt_A=32.
5. Same-cycle accesses: A writes 0x3C to addr 9 while B reads addr 9 (unwritten) → douta_B=0x00 and err_B[0]=1; bank A is unaffected.
6. Assert rst while a RD_LAT=2 read is in flight → no valid pulse follows. Outputs are zero, and cnt=0 after release. Previously written data reads back with err[0] set and value 0 (bitmap cleared).
